// File: rtl/irq_gen.sv
// irq_gen - interrupt conditioning between peripheral sources and the core.
//
// Each of NUM_IRQ lines is synchronised, then conditioned according to its
// 2-bit mode (00 level-high, 01 level-low, 10 rising edge, 11 falling edge).
// Edge lines latch a sticky pending bit, which is cleared by write-1-clear.
// They also flag an overrun when an event arrives on a line that is already
// pending. MASK gates only the IRQ outputs, never the pending state.
//
// Ports:
//   CLK       system clock, all state on rising edge
//   PORESETn  asynchronous active-low reset
//   IRQ_IN    raw interrupt sources               [NUM_IRQ]
//   MODE      per-line mode, bits [2n+1:2n]       [2*NUM_IRQ]
//   MASK      1 = line enabled to core            [NUM_IRQ]
//   SW_SET    one-cycle software set pulse        [NUM_IRQ]
//   CLR       one-cycle write-1-clear pulse       [NUM_IRQ]
//   PENDING   registered pending status           [NUM_IRQ]
//   OVERRUN   sticky lost-edge flag               [NUM_IRQ]
//   IRQ       PENDING & MASK                      [NUM_IRQ]
//   ANY       OR-reduction of IRQ
module irq_gen #(
  parameter int NUM_IRQ     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   PORESETn,
  input  logic [NUM_IRQ-1:0]     IRQ_IN,
  input  logic [2*NUM_IRQ-1:0]   MODE,
  input  logic [NUM_IRQ-1:0]     MASK,
  input  logic [NUM_IRQ-1:0]     SW_SET,
  input  logic [NUM_IRQ-1:0]     CLR,
  output logic [NUM_IRQ-1:0]     PENDING,
  output logic [NUM_IRQ-1:0]     OVERRUN,
  output logic [NUM_IRQ-1:0]     IRQ,
  output logic                   ANY
);

  generate
    if ((NUM_IRQ % 32) != 0 || NUM_IRQ < 32 || NUM_IRQ > 256 ||
        SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_param_check
      $error("irq_gen: NUM_IRQ must be a multiple of 32 in 32..256, SYNC_STAGES 0..3");
    end
  endgenerate

  logic [NUM_IRQ-1:0]   irq_s;
  logic [NUM_IRQ-1:0]   prev_q;
  logic [NUM_IRQ-1:0]   pend_q;
  logic [NUM_IRQ-1:0]   ovr_q;
  logic [2*NUM_IRQ-1:0] mode_q;
  logic [SYNC_STAGES:0] prime_q;
  logic                 armed;
  logic [NUM_IRQ-1:0]   mode_chg;
  logic [NUM_IRQ-1:0]   edge_ev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = IRQ_IN;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge CLK or negedge PORESETn) begin
        if (!PORESETn) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= IRQ_IN;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign irq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // The synchroniser comes out of reset holding zeros. A source held high
  // through reset would otherwise show up as a rising edge once those zeros
  // flush. Edge detection therefore stays off until both the chain and prev
  // hold real samples. With no synchroniser this is the first edge after
  // release.
  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      prime_q <= '0;
    end else begin
      prime_q[0] <= 1'b1;
      for (int i = 1; i <= SYNC_STAGES; i++) prime_q[i] <= prime_q[i-1];
    end
  end

  assign armed = prime_q[SYNC_STAGES];

  always_comb begin
    mode_chg = '0;
    edge_ev  = '0;
    for (int n = 0; n < NUM_IRQ; n++) begin
      mode_chg[n] = (MODE[2*n +: 2] != mode_q[2*n +: 2]);
      edge_ev[n]  = (armed & (MODE[2*n] ? (~irq_s[n] &  prev_q[n])
                                        : ( irq_s[n] & ~prev_q[n])))
                    | SW_SET[n];
    end
  end

  always_ff @(posedge CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      prev_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
      mode_q <= '0;
    end else begin
      prev_q <= irq_s;
      mode_q <= MODE;
      for (int n = 0; n < NUM_IRQ; n++) begin
        if (mode_chg[n]) begin
          // Drop stale state; the new mode is evaluated from the next cycle.
          pend_q[n] <= 1'b0;
          ovr_q[n]  <= 1'b0;
        end else if (!MODE[2*n+1]) begin
          pend_q[n] <= (irq_s[n] ^ MODE[2*n]) | SW_SET[n];
        end else begin
          // An event beats a simultaneous clear so it is never lost.
          if (edge_ev[n])  pend_q[n] <= 1'b1;
          else if (CLR[n]) pend_q[n] <= 1'b0;
          if (edge_ev[n] & pend_q[n] & ~CLR[n]) ovr_q[n] <= 1'b1;
          else if (CLR[n])                      ovr_q[n] <= 1'b0;
        end
      end
    end
  end

  assign PENDING = pend_q;
  assign OVERRUN = ovr_q;
  assign IRQ     = pend_q & MASK;
  assign ANY     = |IRQ;

endmodule

// File: tb/tb_irq_gen.sv
// tb_irq_gen - directed test of irq_gen (NUM_IRQ = 64, SYNC_STAGES = 2).
module tb_irq_gen;

  localparam int N = 64;

  logic           CLK = 1'b0;
  logic           PORESETn;
  logic [N-1:0]   IRQ_IN;
  logic [2*N-1:0] MODE;
  logic [N-1:0]   MASK;
  logic [N-1:0]   SW_SET;
  logic [N-1:0]   CLR;
  logic [N-1:0]   PENDING;
  logic [N-1:0]   OVERRUN;
  logic [N-1:0]   IRQ;
  logic           ANY;

  int n_checks = 0;
  int n_fail   = 0;

  irq_gen #(.NUM_IRQ(N), .SYNC_STAGES(2)) u_dut (
    .CLK      (CLK),
    .PORESETn (PORESETn),
    .IRQ_IN   (IRQ_IN),
    .MODE     (MODE),
    .MASK     (MASK),
    .SW_SET   (SW_SET),
    .CLR      (CLR),
    .PENDING  (PENDING),
    .OVERRUN  (OVERRUN),
    .IRQ      (IRQ),
    .ANY      (ANY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    PORESETn = 1'b0;
    IRQ_IN   = '0;
    IRQ_IN[0] = 1'b1;
    MODE     = '0;
    MODE[1:0] = 2'b10;
    MASK     = '1;
    SW_SET   = '0;
    CLR      = '0;

    tick(3);
    chk("rst_pending", PENDING, 64'h0);
    chk("rst_overrun", OVERRUN, 64'h0);
    chk("rst_irq", IRQ, 64'h0);
    chk("rst_any", 64'(ANY), 64'h0);

    // Source held high through reset must not look like a rising edge.
    PORESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("held_high_no_edge", 64'(PENDING[0]), 64'h0);
    end
    chk("post_release_all", PENDING, 64'h0);

    // Real rising edge: IRQ exactly 3 cycles later.
    IRQ_IN[0] = 1'b0;
    tick(4);
    IRQ_IN[0] = 1'b1;
    tick(2);
    chk("rise_lat_2", 64'(IRQ[0]), 64'h0);
    tick(1);
    chk("rise_lat_3", 64'(IRQ[0]), 64'h1);
    CLR[0] = 1'b1;
    tick(1);
    CLR[0] = 1'b0;
    chk("clr_line0", 64'(IRQ[0]), 64'h0);

    // Line 5 level-high: 4-cycle pulse seen on ticks 3..6.
    IRQ_IN[5] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 4) IRQ_IN[5] = 1'b0;
      chk("lvl_hi_l5", 64'(IRQ[5]), (i >= 3 && i <= 6) ? 64'h1 : 64'h0);
    end

    // Line 5 level-low with input low asserts; CLR ignored.
    MODE[11:10] = 2'b01;
    tick(1);
    chk("lvl_lo_modechg", 64'(PENDING[5]), 64'h0);
    tick(1);
    chk("lvl_lo_l5", 64'(IRQ[5]), 64'h1);
    CLR[5] = 1'b1;
    tick(1);
    CLR[5] = 1'b0;
    chk("lvl_clr_noeffect", 64'(IRQ[5]), 64'h1);
    MODE[11:10] = 2'b00;
    tick(2);
    chk("lvl_back_hi", 64'(IRQ[5]), 64'h0);

    // Line 40 falling edge, overrun, clear.
    MODE[81:80] = 2'b11;
    IRQ_IN[40] = 1'b1;
    tick(5);
    chk("fall_rise_ignored", 64'(PENDING[40]), 64'h0);
    IRQ_IN[40] = 1'b0;
    tick(3);
    chk("fall_pending", 64'(PENDING[40]), 64'h1);
    chk("fall_no_ovr", 64'(OVERRUN[40]), 64'h0);
    IRQ_IN[40] = 1'b1;
    tick(3);
    IRQ_IN[40] = 1'b0;
    tick(3);
    chk("fall_overrun", 64'(OVERRUN[40]), 64'h1);
    chk("fall_still_pend", 64'(PENDING[40]), 64'h1);
    CLR[40] = 1'b1;
    tick(1);
    CLR[40] = 1'b0;
    chk("clr40_pend", 64'(PENDING[40]), 64'h0);
    chk("clr40_ovr", 64'(OVERRUN[40]), 64'h0);
    chk("clr40_irq", 64'(IRQ[40]), 64'h0);

    // Line 7: SW_SET beats CLR, no overrun when already pending.
    MODE[15:14] = 2'b10;
    tick(2);
    SW_SET[7] = 1'b1;
    CLR[7] = 1'b1;
    tick(1);
    SW_SET[7] = 1'b0;
    CLR[7] = 1'b0;
    chk("swset_vs_clr_p0", 64'(PENDING[7]), 64'h1);
    chk("swset_vs_clr_o0", 64'(OVERRUN[7]), 64'h0);
    SW_SET[7] = 1'b1;
    CLR[7] = 1'b1;
    tick(1);
    SW_SET[7] = 1'b0;
    CLR[7] = 1'b0;
    chk("swset_vs_clr_p1", 64'(PENDING[7]), 64'h1);
    chk("swset_vs_clr_o1", 64'(OVERRUN[7]), 64'h0);
    CLR[7] = 1'b1;
    tick(1);
    CLR[7] = 1'b0;
    chk("clr7", 64'(PENDING[7]), 64'h0);

    // Line 3 masked edge still latches; unmask raises IRQ combinationally.
    MODE[7:6] = 2'b10;
    tick(2);
    MASK[3] = 1'b0;
    IRQ_IN[3] = 1'b1;
    tick(3);
    chk("mask_pend", 64'(PENDING[3]), 64'h1);
    chk("mask_irq", 64'(IRQ[3]), 64'h0);
    chk("mask_any", 64'(ANY), 64'h0);
    MASK[3] = 1'b1;
    #1;
    chk("unmask_irq", 64'(IRQ[3]), 64'h1);
    chk("unmask_any", 64'(ANY), 64'h1);

    // Line 2 mode change clears pending, then follows level.
    MODE[5:4] = 2'b10;
    tick(2);
    IRQ_IN[2] = 1'b1;
    tick(3);
    chk("l2_edge_pend", 64'(PENDING[2]), 64'h1);
    MODE[5:4] = 2'b00;
    tick(1);
    chk("l2_modechg_clr", 64'(PENDING[2]), 64'h0);
    tick(1);
    chk("l2_level_follow", 64'(PENDING[2]), 64'h1);

    // Asynchronous reset mid-pending.
    #2;
    PORESETn = 1'b0;
    #1;
    chk("async_rst_pending", PENDING, 64'h0);
    chk("async_rst_overrun", OVERRUN, 64'h0);
    chk("async_rst_irq", IRQ, 64'h0);
    chk("async_rst_any", 64'(ANY), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
